// File: rtl/ec_malf_retry_ctrl_if.sv
// ec_malf_retry_ctrl_if
//   Handshake bundle between the TPU issue logic, the retry controller and
//   one EC datapath lane.
//   slave  : the controller side (ec_malf_retry_ctrl)
//   master : issue logic / datapath side (drives start, op_done, malf_err, fault_clr)
//   Signals:
//     start      operation request, accepted when start && ready
//     ready      controller idle
//     op_go      1-cycle datapath launch pulse
//     op_done    datapath result-valid pulse
//     malf_err   registered malfunction flag, valid the cycle after op_done
//     done/ok    completion pulse, ok=1 clean result, ok=0 fault
//     fault      fault indication
//     retry_cnt  re-executions used by the current/last operation
//     fault_clr  fault acknowledge (sticky-fault build only)
interface ec_malf_retry_ctrl_if #(
    parameter int CNT_W = 2
);
    logic             start;
    logic             ready;
    logic             op_go;
    logic             op_done;
    logic             malf_err;
    logic             done;
    logic             ok;
    logic             fault;
    logic [CNT_W-1:0] retry_cnt;
    logic             fault_clr;

    modport slave (
        input  start, op_done, malf_err, fault_clr,
        output ready, op_go, done, ok, fault, retry_cnt
    );

    modport master (
        output start, op_done, malf_err, fault_clr,
        input  ready, op_go, done, ok, fault, retry_cnt
    );
endinterface

// File: rtl/ec_malf_retry_ctrl.sv
// ec_malf_retry_ctrl
//   Sequences one error-correcting arithmetic operation: launches the
//   datapath, waits for op_done (guarded by a watchdog), samples the
//   registered sign-code malfunction flag and re-executes up to MAX_RETRY
//   times before declaring a fault.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    ec_malf_retry_ctrl_if.slave (see interface header)
//
//   Configuration macro: EC_MALF_STICKY_FAULT_EN
//     defined   : FAULT is a trap state, left only through fault_clr.
//     undefined : FAULT lasts one cycle; fault stays 1 until the next start.
//
//   Every output is a flop; no input reaches an output combinationally.
module ec_malf_retry_ctrl #(
    parameter int MAX_RETRY = 3,
    parameter int CNT_W     = 2,
    parameter int TIMEOUT   = 15,
    parameter int TMO_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ec_malf_retry_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CHECK,
        S_FAULT
    } state_t;

    state_t           state;
    logic             ready_q;
    logic             op_go_q;
    logic             done_q;
    logic             ok_q;
    logic             fault_q;
    logic [CNT_W-1:0] retry_q;
    logic [TMO_W-1:0] wd;
    logic             forced;   // watchdog expired: CHECK treats it as a malfunction

    // The watchdog counts WAIT cycles including the current one, so the
    // timeout fires on the TIMEOUT-th WAIT cycle. op_done is tested first,
    // so a completion coincident with the timeout is a normal completion.
    logic [TMO_W-1:0] wd_inc;
    logic             malf;
    assign wd_inc = wd + TMO_W'(1);
    assign malf   = bus.malf_err | forced;

`ifndef EC_MALF_STICKY_FAULT_EN
    logic unused_fault_clr;
    assign unused_fault_clr = bus.fault_clr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
            op_go_q <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            fault_q <= 1'b0;
            retry_q <= '0;
            wd      <= '0;
            forced  <= 1'b0;
        end else begin
            // pulse outputs default low
            op_go_q <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state   <= S_LAUNCH;
                        op_go_q <= 1'b1;
                        ready_q <= 1'b0;
                        retry_q <= '0;
                        fault_q <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    wd     <= '0;
                    forced <= 1'b0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.op_done) begin
                        state <= S_CHECK;
                    end else if (wd_inc == TMO_W'(TIMEOUT)) begin
                        forced <= 1'b1;
                        state  <= S_CHECK;
                    end else begin
                        wd <= wd_inc;
                    end
                end
                S_CHECK: begin
                    if (!malf) begin
                        state   <= S_IDLE;
                        done_q  <= 1'b1;
                        ok_q    <= 1'b1;
                        ready_q <= 1'b1;
                    end else if (retry_q < CNT_W'(MAX_RETRY)) begin
                        retry_q <= retry_q + CNT_W'(1);
                        op_go_q <= 1'b1;
                        state   <= S_LAUNCH;
                    end else begin
                        state   <= S_FAULT;
                        done_q  <= 1'b1;
                        fault_q <= 1'b1;
                    end
                end
                S_FAULT: begin
`ifdef EC_MALF_STICKY_FAULT_EN
                    if (bus.fault_clr) begin
                        state   <= S_IDLE;
                        fault_q <= 1'b0;
                        retry_q <= '0;
                        ready_q <= 1'b1;
                    end
`else
                    // fault stays visible until the next accepted start
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
`endif
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.op_go     = op_go_q;
    assign bus.done      = done_q;
    assign bus.ok        = ok_q;
    assign bus.fault     = fault_q;
    assign bus.retry_cnt = retry_q;

endmodule

// File: tb/tb_ec_malf_retry_ctrl.sv
module tb_ec_malf_retry_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ec_malf_retry_ctrl_if #(.CNT_W(2)) bus ();

    ec_malf_retry_ctrl #(
        .MAX_RETRY(3), .CNT_W(2), .TIMEOUT(15), .TMO_W(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int ok;
        int fault;
        int rc;
        int ngo;
        int lat;   // expected cycles from op_done to done, 0 = not checked
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int gocnt = 0;
    int last_od = 0;

    int  dly_q [8];   // op_done delay after op_go, -1 = never (timeout)
    bit  malf_q[8];
    int  go_tick[8];
    bit  poke;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        if (!rst_n) begin
            gocnt = 0;
        end else begin
            if (bus.op_go) gocnt++;
            if (bus.op_done) last_od = cyc;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_ok", 32'(bus.ok), e.ok);
                    chk("done_fault", 32'(bus.fault), e.fault);
                    chk("done_retry_cnt", 32'(bus.retry_cnt), e.rc);
                    chk("op_go_count", gocnt, e.ngo);
                    if (e.lat != 0) chk("done_latency", cyc - last_od, e.lat);
                end
                gocnt = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ok, input int fault, input int rc, input int ngo, input int lat);
        exp_t e;
        e.ok = ok; e.fault = fault; e.rc = rc; e.ngo = ngo; e.lat = lat;
        sb.push_back(e);
    endtask

    // drives start, then plays the datapath for natt attempts
    task automatic run_op(input int natt);
        int t;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int a = 0; a < natt; a++) begin
            t = 0;
            while (!bus.op_go && t < 40) begin
                tick();
                t++;
            end
            go_tick[a] = t;
            if (!bus.op_go) begin
                chk("op_go_wait_timeout", 0, 1);
                return;
            end
            if (dly_q[a] < 0) begin
                tick();   // leave the LAUNCH cycle; watchdog must fire
            end else begin
                if (poke && a == 0) begin
                    tick();
                    bus.start = 1'b1;
                    tick();
                    bus.start = 1'b0;
                    repeat (dly_q[a] - 2) tick();
                end else begin
                    repeat (dly_q[a]) tick();
                end
                bus.op_done = 1'b1;
                tick();
                bus.op_done  = 1'b0;
                bus.malf_err = malf_q[a];
                tick();
                bus.malf_err = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bus.start = 1'b0; bus.op_done = 1'b0; bus.malf_err = 1'b0; bus.fault_clr = 1'b0;
        poke = 1'b0;
        #12;
        chk("rst_ready", 32'(bus.ready), 1);
        chk("rst_op_go", 32'(bus.op_go), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_fault", 32'(bus.fault), 0);
        chk("rst_retry_cnt", 32'(bus.retry_cnt), 0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // 1: clean first try, op_done 4 cycles after op_go
        dly_q[0] = 4; malf_q[0] = 0;
        push(1, 0, 0, 1, 2);
        run_op(1);
        chk("t1_ready", 32'(bus.ready), 1);
        repeat (2) tick();

        // 2: one malfunction then clean
        dly_q[0] = 3; malf_q[0] = 1;
        dly_q[1] = 2; malf_q[1] = 0;
        push(1, 0, 1, 2, 2);
        run_op(2);
        repeat (2) tick();

        // 3: four malfunctions -> fault
        for (int a = 0; a < 4; a++) begin dly_q[a] = 2; malf_q[a] = 1; end
        push(0, 1, 3, 4, 2);
        run_op(4);
        tick();
`ifdef EC_MALF_STICKY_FAULT_EN
        repeat (4) tick();
        chk("t3_sticky_ready", 32'(bus.ready), 0);
        chk("t3_sticky_fault", 32'(bus.fault), 1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("t3_sticky_no_go", 32'(bus.op_go), 0);
        chk("t3_sticky_ready2", 32'(bus.ready), 0);
        bus.fault_clr = 1'b1;
        tick();
        bus.fault_clr = 1'b0;
        chk("t3_clr_ready", 32'(bus.ready), 1);
        chk("t3_clr_fault", 32'(bus.fault), 0);
        chk("t3_clr_retry_cnt", 32'(bus.retry_cnt), 0);
`else
        chk("t3_ready_after", 32'(bus.ready), 1);
        chk("t3_fault_held", 32'(bus.fault), 1);
        repeat (3) tick();
        chk("t3_fault_held2", 32'(bus.fault), 1);
        chk("t3_retry_held", 32'(bus.retry_cnt), 3);
`endif

        // 4a: first attempt times out, second is clean
        dly_q[0] = -1;
        dly_q[1] = 2; malf_q[1] = 0;
        push(1, 0, 1, 2, 2);
        run_op(2);
        // op_go at cycle 1, WAIT 2..16, CHECK 17, relaunch 18
        chk("t4_timeout_relaunch", go_tick[1] + 1, 17);
        repeat (2) tick();

        // 4b: op_done on the 15th WAIT cycle is a normal completion
        dly_q[0] = 15; malf_q[0] = 0;
        push(1, 0, 0, 1, 2);
        run_op(1);
        repeat (2) tick();

        // 5: reset while in WAIT with retry_cnt=2
        dly_q[0] = 2; malf_q[0] = 1;
        dly_q[1] = 2; malf_q[1] = 1;
        run_op(2);
        repeat (2) tick();
        chk("t5_pre_retry_cnt", 32'(bus.retry_cnt), 2);
        rst_n = 1'b0;
        #1;
        chk("t5_ready", 32'(bus.ready), 1);
        chk("t5_op_go", 32'(bus.op_go), 0);
        chk("t5_done", 32'(bus.done), 0);
        chk("t5_fault", 32'(bus.fault), 0);
        chk("t5_retry_cnt", 32'(bus.retry_cnt), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (25) tick();

        // 6: start during WAIT ignored, stray op_done in IDLE ignored
        poke = 1'b1;
        dly_q[0] = 5; malf_q[0] = 0;
        push(1, 0, 0, 1, 2);
        run_op(1);
        poke = 1'b0;
        tick();
        bus.op_done = 1'b1;
        tick();
        bus.op_done = 1'b0;
        repeat (5) tick();
        chk("t6_ready", 32'(bus.ready), 1);
        chk("t6_no_stray_go", gocnt, 0);

        repeat (3) tick();
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
